// File: rtl/counter_arbiter_pkg.sv
// Shared types and constants for the counter arbiter.
// Used by the interface, the controller and the interval counter.
package counter_arbiter_pkg;

    localparam int CNT_W   = 10;
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    // Index width for n requesters; a lone requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_arbiter_if.sv
// Requester-side bundle of the counter arbiter.
// The master drives requests and the slave returns grant and completion.
interface counter_arbiter_if #(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]                            req;
    logic [NUM_REQ*counter_arbiter_pkg::CNT_W-1:0] req_len;
    logic                                          pause;
    logic [NUM_REQ-1:0]                            grant;
    logic [NUM_REQ-1:0]                            done;
    logic                                          busy;
    logic [counter_arbiter_pkg::CNT_W-1:0]         count_out;

    modport master (
        output req,
        output req_len,
        output pause,
        input  grant,
        input  done,
        input  busy,
        input  count_out
    );

    modport slave (
        input  req,
        input  req_len,
        input  pause,
        output grant,
        output done,
        output busy,
        output count_out
    );

endinterface

// File: rtl/counter_10bit.sv
// Interval counter: counts 1..rollover_val after a clear, then wraps to 1.
// rollover_flag is a live compare, so it is high while the terminal value is held.
module counter_10bit
    import counter_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [CNT_W-1:0] rollover_val,
    output logic [CNT_W-1:0] count_out,
    output logic             rollover_flag
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            if (count_out == rollover_val) begin
                count_out <= CNT_W'(1);
            end else begin
                count_out <= count_out + CNT_W'(1);
            end
        end
    end

    assign rollover_flag = (count_out == rollover_val);

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin time-slot arbiter sharing one interval counter among requesters.
// Grant and done decode only from registered state, never from inputs.
module counter_arbiter
    import counter_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
)
(
    input logic               clk,
    input logic               rst,
    counter_arbiter_if.slave  bus
);

    localparam int IDX_W = idx_width(NUM_REQ);

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   next_idx;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   next_ptr;
    logic [IDX_W-1:0]   pick;
    logic [CNT_W-1:0]   len;
    logic [CNT_W-1:0]   next_len;
    logic [CNT_W-1:0]   count_val;
    logic [CNT_W-1:0]   len_arr [NUM_REQ];
    logic [NUM_REQ-1:0] owner_onehot;
    logic               owner_req;
    logic               abort;
    logic               clear;
    logic               count_enable;
    logic               rollover_flag;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign len_arr[i] = bus.req_len[i*CNT_W +: CNT_W];
    end

    // First requesting index after p, wrapping, so the last owner goes to the back.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [IDX_W-1:0]   p
    );
        logic [IDX_W-1:0] pick_i;
        logic [IDX_W-1:0] cand;
        logic             found;
        pick_i = p;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(p) + k) % NUM_REQ);
            if (!found && r[cand]) begin
                pick_i = cand;
                found  = 1'b1;
            end
        end
        return pick_i;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            ptr   <= IDX_W'(NUM_REQ - 1);
            len   <= '0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
            ptr   <= next_ptr;
            len   <= next_len;
        end
    end

    assign owner_req = bus.req[idx];
    assign pick      = rr_pick(bus.req, ptr);

    always_comb begin
        next_state   = state;
        next_idx     = idx;
        next_ptr     = ptr;
        next_len     = len;
        count_enable = 1'b0;
        abort        = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    next_idx   = pick;
                    next_len   = len_arr[pick];
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (!owner_req) begin
                    abort      = 1'b1;
                    next_ptr   = idx;
                    next_state = IDLE;
                end else if (len == '0) begin
                    next_state = DONE;
                end else begin
                    next_state = RUN;
                end
            end
            RUN: begin
                count_enable = !bus.pause && !rollover_flag;
                // A dropped request wins over a simultaneous rollover: no done pulse.
                if (!owner_req) begin
                    abort      = 1'b1;
                    next_ptr   = idx;
                    next_state = IDLE;
                end else if (rollover_flag) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_ptr   = idx;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign clear        = rst || (state == LOAD) || abort;
    assign owner_onehot = NUM_REQ'(1) << idx;

    assign bus.grant     = ((state == LOAD) || (state == RUN)) ? owner_onehot : '0;
    assign bus.done      = (state == DONE) ? owner_onehot : '0;
    assign bus.busy      = (state != IDLE);
    assign bus.count_out = count_val;

    counter_10bit u_counter (
        .clk           (clk),
        .n_rst         (1'b1),
        .clear         (clear),
        .count_enable  (count_enable),
        .rollover_val  (len),
        .count_out     (count_val),
        .rollover_flag (rollover_flag)
    );

endmodule
